// File: rtl/uart_sv_if.sv
// Host-side FIFO ports and serial line pair of uart_sv, grouped for connection.
// The slave modport is the UART's view; master is the host/line driver's view.
interface uart_sv_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] TxData;
    logic                 TxWrite;
    logic                 TxFull;
    logic                 TxEmpty;
    logic                 TxD;
    logic                 RxD;
    logic                 RxRead;
    logic [DATA_BITS-1:0] RxData;
    logic                 RxParityErr;
    logic                 RxFrameErr;
    logic                 RxEmpty;
    logic                 RxFull;
    logic                 RxOverrun;

    modport master (
        output TxData, TxWrite, RxD, RxRead,
        input  TxFull, TxEmpty, TxD, RxData, RxParityErr, RxFrameErr,
               RxEmpty, RxFull, RxOverrun
    );

    modport slave (
        input  TxData, TxWrite, RxD, RxRead,
        output TxFull, TxEmpty, TxD, RxData, RxParityErr, RxFrameErr,
               RxEmpty, RxFull, RxOverrun
    );
endinterface

// File: rtl/uart_sv.sv
// Full-duplex UART with TX/RX FIFOs; frame = start, data LSB first, parity, stop bits.
// Define UART_ODD_PARITY_EN for odd parity on both directions (even parity otherwise).
module uart_sv #(
    parameter int SYSCLK_RATE = 4,
    parameter int BAUD_RATE   = 1,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input logic      SysClk,
    input logic      Reset_n,
    uart_sv_if.slave bus
);
    localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W        = $clog2(FIFO_DEPTH + 1);
    localparam int RX_W         = DATA_BITS + 2;
`ifdef UART_ODD_PARITY_EN
    localparam logic PAR_INV = 1'b1;
`else
    localparam logic PAR_INV = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     tx_wr_ptr, tx_rd_ptr;
    logic [OCC_W-1:0]     tx_count;
    logic                 tx_full, tx_push, tx_pop;

    assign tx_full = (tx_count == OCC_W'(FIFO_DEPTH));
    assign tx_push = bus.TxWrite && !tx_full;

    always_ff @(posedge SysClk)
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.TxData;

    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= next_ptr(tx_wr_ptr);
            if (tx_pop)  tx_rd_ptr <= next_ptr(tx_rd_ptr);
            if (tx_push && !tx_pop)      tx_count <= tx_count + OCC_W'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - OCC_W'(1);
        end
    end

    // ---------------- TX FSM ----------------
    state_t             tx_state;
    logic [CNT_W-1:0]   tx_cnt;
    logic [3:0]         tx_bit;
    logic [DATA_BITS:0] tx_sh;
    logic               tx_par, tx_line, tx_bit_end, tx_frame_end;

    assign tx_bit_end   = (tx_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign tx_frame_end = (tx_state == STOP) && tx_bit_end && (tx_bit == 4'(STOP_BITS - 1));
    // Reloading straight from the last stop bit keeps back-to-back frames gapless.
    assign tx_pop       = (tx_count != '0) && ((tx_state == IDLE) || tx_frame_end);

    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= START;
            tx_sh    <= {1'b0, tx_mem[tx_rd_ptr]};
            tx_par   <= (^tx_mem[tx_rd_ptr]) ^ PAR_INV;
            tx_cnt   <= '0;
            tx_line  <= 1'b0;
        end else begin
            if (tx_state != IDLE) tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
            case (tx_state)
                IDLE: tx_line <= 1'b1;
                START: if (tx_bit_end) begin
                    tx_state <= DATA;
                    tx_bit   <= '0;
                    tx_line  <= tx_sh[0];
                end
                DATA: if (tx_bit_end) begin
                    if (tx_bit == 4'(DATA_BITS - 1)) begin
                        tx_state <= PARITY;
                        tx_line  <= tx_par;
                    end else begin
                        tx_bit  <= tx_bit + 4'd1;
                        tx_sh   <= tx_sh >> 1;
                        tx_line <= tx_sh[1];
                    end
                end
                PARITY: if (tx_bit_end) begin
                    tx_state <= STOP;
                    tx_bit   <= '0;
                    tx_line  <= 1'b1;
                end
                STOP: if (tx_bit_end) begin
                    if (tx_frame_end) tx_state <= IDLE;
                    else              tx_bit   <= tx_bit + 4'd1;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    assign bus.TxD     = tx_line;
    assign bus.TxFull  = tx_full;
    assign bus.TxEmpty = (tx_count == '0) && (tx_state == IDLE);

    // ---------------- RX FSM ----------------
    state_t               rx_state;
    logic                 rx_s1, rx_s2, rx_prev;
    logic [CNT_W-1:0]     rx_cnt;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_perr, rx_ferr, rx_push, rx_bit_end;
    logic [RX_W-1:0]      rx_word;

    assign rx_bit_end = (rx_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_push  <= 1'b0;
            rx_word  <= '0;
        end else begin
            rx_s1   <= bus.RxD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_push <= 1'b0;
            case (rx_state)
                IDLE: if (rx_prev && !rx_s2) begin
                    rx_state <= START;
                    rx_cnt   <= '0;
                end
                START: if (rx_cnt == CNT_W'(HALF_BIT - 1)) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? IDLE : DATA;
                end else rx_cnt <= rx_cnt + CNT_W'(1);
                DATA: if (rx_bit_end) begin
                    rx_cnt <= '0;
                    for (int i = 0; i < DATA_BITS; i++)
                        if (rx_bit == 4'(i)) rx_sh[i] <= rx_s2;
                    if (rx_bit == 4'(DATA_BITS - 1)) rx_state <= PARITY;
                    else                             rx_bit   <= rx_bit + 4'd1;
                end else rx_cnt <= rx_cnt + CNT_W'(1);
                PARITY: if (rx_bit_end) begin
                    rx_cnt   <= '0;
                    rx_perr  <= rx_s2 != ((^rx_sh) ^ PAR_INV);
                    rx_ferr  <= 1'b0;
                    rx_bit   <= '0;
                    rx_state <= STOP;
                end else rx_cnt <= rx_cnt + CNT_W'(1);
                STOP: if (rx_bit_end) begin
                    rx_cnt <= '0;
                    if (rx_bit == 4'(STOP_BITS - 1)) begin
                        rx_push  <= 1'b1;
                        rx_word  <= {rx_ferr | ~rx_s2, rx_perr, rx_sh};
                        rx_state <= IDLE;
                    end else begin
                        rx_ferr <= rx_ferr | ~rx_s2;
                        rx_bit  <= rx_bit + 4'd1;
                    end
                end else rx_cnt <= rx_cnt + CNT_W'(1);
                default: rx_state <= IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [RX_W-1:0]  rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [OCC_W-1:0] rx_count;
    logic             rx_full, rx_empty, rx_pop, rx_accept, rx_overrun;
    logic [RX_W-1:0]  rx_head;

    assign rx_full   = (rx_count == OCC_W'(FIFO_DEPTH));
    assign rx_empty  = (rx_count == '0);
    assign rx_pop    = bus.RxRead && !rx_empty;
    // A simultaneous read frees the slot the incoming word needs.
    assign rx_accept = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge SysClk)
        if (rx_accept) rx_mem[rx_wr_ptr] <= rx_word;

    always_ff @(posedge SysClk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            rx_count   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_accept) rx_wr_ptr <= next_ptr(rx_wr_ptr);
            if (rx_pop)    rx_rd_ptr <= next_ptr(rx_rd_ptr);
            if (rx_accept && !rx_pop)      rx_count <= rx_count + OCC_W'(1);
            else if (!rx_accept && rx_pop) rx_count <= rx_count - OCC_W'(1);
            if (rx_push && !rx_accept) rx_overrun <= 1'b1;
            else if (rx_pop)           rx_overrun <= 1'b0;
        end
    end

    assign rx_head         = rx_empty ? '0 : rx_mem[rx_rd_ptr];
    assign bus.RxData      = rx_head[DATA_BITS-1:0];
    assign bus.RxParityErr = rx_head[DATA_BITS];
    assign bus.RxFrameErr  = rx_head[DATA_BITS+1];
    assign bus.RxEmpty     = rx_empty;
    assign bus.RxFull      = rx_full;
    assign bus.RxOverrun   = rx_overrun;
endmodule

// File: tb/tb_uart_sv.sv
// Bench for uart_sv at default parameters: directed sequence with random data words,
// expected serial frames and received words derived from the frame-format rules.
module tb_uart_sv;
    localparam int DB  = 8;
    localparam int CPB = 4;
`ifdef UART_ODD_PARITY_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic loop_en;
    logic rx_drv;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_sv_if #(.DATA_BITS(DB)) bus ();
    assign bus.RxD = loop_en ? bus.TxD : rx_drv;

    uart_sv #(
        .SYSCLK_RATE(4), .BAUD_RATE(1), .DATA_BITS(DB), .STOP_BITS(2), .FIFO_DEPTH(8)
    ) dut (
        .SysClk (clk),
        .Reset_n(rst_n),
        .bus    (bus)
    );

    function automatic bit par_of(input logic [7:0] d);
        return (^d) ^ ODD;
    endfunction

    // Line levels of one frame, index 0 transmitted first.
    function automatic logic [11:0] frame_of(input logic [7:0] d);
        return {2'b11, par_of(d), d, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        bus.TxData  = d;
        bus.TxWrite = 1'b1;
        tick();
        bus.TxWrite = 1'b0;
    endtask

    task automatic rx_read();
        bus.RxRead = 1'b1;
        tick();
        bus.RxRead = 1'b0;
    endtask

    task automatic wait_tx_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.TxD === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_tx_empty(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (bus.TxEmpty === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // Samples TxD mid-bit, returns the data and checks framing bits.
    task automatic capture_frame(output logic [7:0] d);
        bit ok;
        wait_tx_low(ok);
        chk("tx_frame_found", 32'(ok), 32'd1);
        d = '0;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            tick(CPB);
            d[i] = bus.TxD;
        end
        tick(CPB);
        chk("tx_parity_bit", 32'(bus.TxD), 32'(par_of(d)));
        tick(CPB);
        chk("tx_stop1", 32'(bus.TxD), 32'd1);
        tick(CPB);
        chk("tx_stop2", 32'(bus.TxD), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] d, input bit p, input bit s1, input bit s2);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(CPB);
        end
        rx_drv = p;
        tick(CPB);
        rx_drv = s1;
        tick(CPB);
        rx_drv = s2;
        tick(CPB);
        rx_drv = 1'b1;
        tick(6);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [11:0] fb;
        logic [7:0]  exp_q[$];
        logic [7:0]  got_q[$];
        bit          ok;
        bit          all_high;

        rst_n       = 1'b0;
        loop_en     = 1'b0;
        rx_drv      = 1'b1;
        bus.TxData  = '0;
        bus.TxWrite = 1'b0;
        bus.RxRead  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();

        chk("rst_txd", 32'(bus.TxD), 32'd1);
        chk("rst_tx_empty", 32'(bus.TxEmpty), 32'd1);
        chk("rst_tx_full", 32'(bus.TxFull), 32'd0);
        chk("rst_rx_empty", 32'(bus.RxEmpty), 32'd1);
        chk("rst_rx_full", 32'(bus.RxFull), 32'd0);
        chk("rst_rx_data", 32'(bus.RxData), 32'd0);
        chk("rst_errs", 32'({bus.RxParityErr, bus.RxFrameErr, bus.RxOverrun}), 32'd0);

        // Exact TxD waveform for 0xA5.
        fb = frame_of(8'hA5);
        tx_write(8'hA5);
        chk("a5_pre_start", 32'(bus.TxD), 32'd1);
        chk("a5_tx_busy", 32'(bus.TxEmpty), 32'd0);
        tick();
        for (int i = 0; i < 12 * CPB; i++) begin
            chk($sformatf("a5_cycle%0d", i), 32'(bus.TxD), 32'(fb[i / CPB]));
            tick();
        end
        chk("a5_idle", 32'(bus.TxD), 32'd1);
        chk("a5_tx_empty", 32'(bus.TxEmpty), 32'd1);

        // Loopback 0x3C, 0xFF.
        loop_en = 1'b1;
        tx_write(8'h3C);
        tx_write(8'hFF);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.RxEmpty === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("loop_rx_arrive", 32'(ok), 32'd1);
        chk("loop_data0", 32'(bus.RxData), 32'h3C);
        chk("loop_errs0", 32'({bus.RxParityErr, bus.RxFrameErr}), 32'd0);
        wait_tx_empty("loop_tx_done");
        tick(12);
        rx_read();
        chk("loop_data1", 32'(bus.RxData), 32'hFF);
        chk("loop_errs1", 32'({bus.RxParityErr, bus.RxFrameErr}), 32'd0);
        rx_read();
        chk("loop_rx_empty", 32'(bus.RxEmpty), 32'd1);

        // Loopback random words.
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            tx_write(d);
        end
        wait_tx_empty("rand_tx_done");
        tick(12);
        for (int i = 0; i < 5; i++) begin
            chk("rand_rx_avail", 32'(bus.RxEmpty), 32'd0);
            chk("rand_rx_data", 32'(bus.RxData), 32'(exp_q[i]));
            chk("rand_rx_errs", 32'({bus.RxParityErr, bus.RxFrameErr}), 32'd0);
            rx_read();
        end
        chk("rand_rx_empty", 32'(bus.RxEmpty), 32'd1);
        loop_en = 1'b0;
        tick(4);

        // Ten consecutive writes: one in the shifter plus a full FIFO, the tenth dropped.
        exp_q.delete();
        got_q.delete();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    d = 8'($urandom_range(0, 255));
                    if (i < 9) exp_q.push_back(d);
                    tx_write(d);
                    chk($sformatf("burst_full_after%0d", i + 1), 32'(bus.TxFull), 32'(i >= 8));
                end
            end
            begin
                logic [7:0] c;
                for (int f = 0; f < 9; f++) begin
                    capture_frame(c);
                    got_q.push_back(c);
                end
            end
        join
        for (int f = 0; f < 9; f++)
            chk($sformatf("burst_frame%0d", f), 32'(got_q[f]), 32'(exp_q[f]));
        all_high = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.TxD !== 1'b1) all_high = 1'b0;
            tick();
        end
        chk("burst_no_tenth", 32'(all_high), 32'd1);
        chk("burst_tx_empty", 32'(bus.TxEmpty), 32'd1);

        // Directed RX error frames.
        send_rx(8'h01, ~par_of(8'h01), 1'b1, 1'b1);
        chk("perr_avail", 32'(bus.RxEmpty), 32'd0);
        chk("perr_data", 32'(bus.RxData), 32'h01);
        chk("perr_flag", 32'(bus.RxParityErr), 32'd1);
        chk("perr_no_ferr", 32'(bus.RxFrameErr), 32'd0);
        rx_read();
        send_rx(8'h01, par_of(8'h01), 1'b0, 1'b1);
        chk("ferr_data", 32'(bus.RxData), 32'h01);
        chk("ferr_flag", 32'(bus.RxFrameErr), 32'd1);
        chk("ferr_no_perr", 32'(bus.RxParityErr), 32'd0);
        rx_read();
        chk("err_rx_empty", 32'(bus.RxEmpty), 32'd1);

        // RX FIFO fill and overrun.
        for (int i = 0; i < 9; i++) begin
            d = 8'(i + 1);
            send_rx(d, par_of(d), 1'b1, 1'b1);
            if (i == 6) chk("ovr_not_full7", 32'(bus.RxFull), 32'd0);
            if (i == 7) begin
                chk("ovr_full8", 32'(bus.RxFull), 32'd1);
                chk("ovr_clear8", 32'(bus.RxOverrun), 32'd0);
            end
        end
        chk("ovr_set9", 32'(bus.RxOverrun), 32'd1);
        chk("ovr_still_full", 32'(bus.RxFull), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovr_read%0d", i), 32'(bus.RxData), 32'(i + 1));
            rx_read();
            if (i == 0) begin
                chk("ovr_cleared", 32'(bus.RxOverrun), 32'd0);
                chk("ovr_not_full", 32'(bus.RxFull), 32'd0);
            end
        end
        chk("ovr_rx_empty", 32'(bus.RxEmpty), 32'd1);

        // Reset in the middle of a TX frame.
        d = 8'($urandom_range(0, 255));
        send_rx(d, par_of(d), 1'b1, 1'b1);
        chk("mid_rst_rx_loaded", 32'(bus.RxEmpty), 32'd0);
        tx_write(8'($urandom_range(0, 255)));
        wait_tx_low(ok);
        chk("mid_rst_start", 32'(ok), 32'd1);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", 32'(bus.TxD), 32'd1);
        chk("mid_rst_tx_empty", 32'(bus.TxEmpty), 32'd1);
        chk("mid_rst_rx_empty", 32'(bus.RxEmpty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        d = 8'($urandom_range(0, 255));
        tx_write(d);
        capture_frame(fb[7:0]);
        chk("post_rst_frame", 32'(fb[7:0]), 32'(d));
        tick(4);
        chk("post_rst_tx_empty", 32'(bus.TxEmpty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
